// File: rtl/adc_conv_sequencer.sv
// Timing master for the AD4003 deserializer array: shared CNVST/SCK/SDI sequencing,
// delayed-read valid strobe and configuration write frames for every channel.
module adc_conv_sequencer #(
  parameter int unsigned ADC_DATA_WIDTH = 18,
  parameter int unsigned CONV_CYCLES    = 26,
  parameter int unsigned PERIOD_CYCLES  = 80,
  parameter int unsigned READ_LAT       = 4,
  parameter int unsigned WR_BITS        = 16,
  parameter int unsigned TCQ            = 1
) (
  input  logic               adc_spi_clk,
  input  logic               rstn,
  input  logic               acq_en,
  input  logic               force_write,
  input  logic [WR_BITS-1:0] cfg_word,
  output logic               cnvst,
  output logic               sck_en,
  output logic               sdi,
  output logic               reader_en_sync,
  output logic               frame_start,
  output logic               data_valid,
  output logic [31:0]        sample_cnt,
  output logic               busy
);

  localparam int unsigned MaxPhase =
      (CONV_CYCLES > ADC_DATA_WIDTH) ?
      ((CONV_CYCLES > WR_BITS) ? CONV_CYCLES : WR_BITS) :
      ((ADC_DATA_WIDTH > WR_BITS) ? ADC_DATA_WIDTH : WR_BITS);
  localparam int unsigned StepW   = $clog2(MaxPhase + 1);
  localparam int unsigned PeriodW = $clog2(PERIOD_CYCLES + 1);

  if (PERIOD_CYCLES < CONV_CYCLES + ADC_DATA_WIDTH + READ_LAT + 1) begin : g_param_check
    $error("adc_conv_sequencer: PERIOD_CYCLES shorter than CONV + READ + READ_LAT + 1");
  end

  // Registers are modelled without clock-to-Q delay; the parameter is kept for instantiation.
  logic unused_tcq;
  assign unused_tcq = ^TCQ;

  typedef enum logic [2:0] {StIdle, StWrite, StConv, StRead, StWait} state_e;

  state_e               state_q, state_d;
  logic [StepW-1:0]     step_q, step_d;
  logic [PeriodW-1:0]   period_q, period_d;
  logic                 wr_pending_q, wr_pending_d;
  logic [WR_BITS-1:0]   cfg_q;
  logic [READ_LAT-1:0]  valid_pipe_q;
  logic                 wr_req, wr_load, go_write, go_conv, read_last;

  // A request arriving on the decision edge is honoured without waiting a cycle.
  assign wr_req    = wr_pending_q | force_write;
  assign read_last = (state_q == StRead) && (step_q == StepW'(ADC_DATA_WIDTH - 1));

  always_comb begin
    state_d      = state_q;
    step_d       = step_q + StepW'(1);
    period_d     = period_q + PeriodW'(1);
    wr_pending_d = wr_pending_q | force_write;
    wr_load      = 1'b0;
    go_write     = 1'b0;
    go_conv      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_req) begin
          go_write = 1'b1;
        end else if (acq_en) begin
          go_conv = 1'b1;
        end
      end
      StWrite: begin
        if (step_q == StepW'(WR_BITS - 1)) begin
          if (acq_en) begin
            go_conv = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StConv: begin
        if (step_q == StepW'(CONV_CYCLES - 1)) begin
          state_d = StRead;
          step_d  = '0;
        end
      end
      StRead: begin
        if (read_last) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (period_q == PeriodW'(PERIOD_CYCLES - 1)) begin
          if (wr_req) begin
            go_write = 1'b1;
          end else if (acq_en) begin
            go_conv = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (go_write) begin
      state_d      = StWrite;
      step_d       = '0;
      wr_pending_d = 1'b0;
      wr_load      = 1'b1;
    end
    if (go_conv) begin
      state_d  = StConv;
      step_d   = '0;
      period_d = '0;
    end
  end

  always_ff @(posedge adc_spi_clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      step_q       <= '0;
      period_q     <= '0;
      wr_pending_q <= 1'b0;
      cfg_q        <= '0;
      valid_pipe_q <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      period_q     <= period_d;
      wr_pending_q <= wr_pending_d;
      if (wr_load) begin
        cfg_q <= cfg_word;
      end else if (state_q == StWrite) begin
        cfg_q <= {cfg_q[WR_BITS-2:0], 1'b0};
      end
      // Delay pipe runs independently of the state so the strobe survives a state change.
      valid_pipe_q <= READ_LAT'({valid_pipe_q, read_last});
    end
  end

  always_ff @(posedge adc_spi_clk) begin
    if (!rstn) begin
      cnvst          <= 1'b0;
      sck_en         <= 1'b0;
      sdi            <= 1'b0;
      reader_en_sync <= 1'b0;
      frame_start    <= 1'b0;
      data_valid     <= 1'b0;
      sample_cnt     <= '0;
      busy           <= 1'b0;
    end else begin
      cnvst          <= (state_q == StConv);
      sck_en         <= (state_q == StWrite) || (state_q == StRead);
      sdi            <= (state_q == StWrite) && cfg_q[WR_BITS-1];
      reader_en_sync <= (state_q == StRead);
      frame_start    <= (state_q == StConv) && (step_q == '0);
      data_valid     <= valid_pipe_q[READ_LAT-1];
      busy           <= (state_q != StIdle);
      if (valid_pipe_q[READ_LAT-1]) begin
        sample_cnt <= sample_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Self-checking bench for adc_conv_sequencer: event scoreboard for frame_start/data_valid,
// table-driven configuration writes and hand-written multi-cycle corner sequences.
module tb_adc_conv_sequencer;

  localparam int unsigned AdcBits   = 18;
  localparam int unsigned ConvCyc   = 26;
  localparam int unsigned PeriodCyc = 80;
  localparam int unsigned ReadLat   = 4;
  localparam int unsigned WrBits    = 16;
  localparam int unsigned DvOfs     = ConvCyc + AdcBits + ReadLat - 1;
  localparam int unsigned WrSpace   = PeriodCyc + WrBits;

  logic        clk = 1'b0;
  logic        rstn, acq_en, force_write;
  logic [15:0] cfg_word;
  logic        cnvst, sck_en, sdi, reader_en_sync, frame_start, data_valid, busy;
  logic [31:0] sample_cnt;

  adc_conv_sequencer dut (
    .adc_spi_clk   (clk),
    .rstn          (rstn),
    .acq_en        (acq_en),
    .force_write   (force_write),
    .cfg_word      (cfg_word),
    .cnvst         (cnvst),
    .sck_en        (sck_en),
    .sdi           (sdi),
    .reader_en_sync(reader_en_sync),
    .frame_start   (frame_start),
    .data_valid    (data_valid),
    .sample_cnt    (sample_cnt),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned fs_q[$];
  int unsigned dv_q[$];

  int unsigned exp_samples = 0, cnvst_cycles = 0, cnv_run = 0, sck_run = 0;
  int unsigned wr_frames = 0, last_wr_len = 0;
  logic [15:0] wr_cap = '0, last_wr_stream = '0;
  logic        prev_cnvst = 1'b0, prev_sck = 1'b0, run_rd = 1'b0;

  typedef struct {
    logic [15:0] cfg;
    logic [15:0] exp_stream;
    int unsigned exp_len;
  } wr_vec_t;
  wr_vec_t wr_tab [4];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) tick();
  endtask

  // Monitor: pops expected events as the DUT produces them and checks burst shapes.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        exp_samples = 0;
        cnv_run     = 0;
        sck_run     = 0;
        run_rd      = 1'b0;
        prev_cnvst  = 1'b0;
        prev_sck    = 1'b0;
        wr_cap      = '0;
      end else begin
        if (frame_start) begin
          check("frame_start_expected", 32'(fs_q.size() != 0), 1);
          if (fs_q.size() != 0) check("frame_start_cycle", cyc, fs_q.pop_front());
        end
        if (data_valid) begin
          check("data_valid_expected", 32'(dv_q.size() != 0), 1);
          if (dv_q.size() != 0) check("data_valid_cycle", cyc, dv_q.pop_front());
          exp_samples++;
          check("sample_cnt_on_valid", sample_cnt, exp_samples);
        end
        if (reader_en_sync) check("reader_en_gated_by_sck", 32'(sck_en), 1);
        if (cnvst) begin
          cnvst_cycles++;
          cnv_run++;
          check("cnvst_sck_overlap", 32'(sck_en), 0);
        end else if (prev_cnvst) begin
          check("cnvst_len", cnv_run, ConvCyc);
          cnv_run = 0;
        end
        if (sck_en) begin
          sck_run++;
          if (reader_en_sync) begin
            run_rd = 1'b1;
            check("read_sdi_low", 32'(sdi), 0);
          end else begin
            wr_cap = {wr_cap[14:0], sdi};
          end
        end else if (prev_sck) begin
          if (run_rd) begin
            check("read_len", sck_run, AdcBits);
          end else begin
            wr_frames++;
            last_wr_len    = sck_run;
            last_wr_stream = wr_cap;
          end
          sck_run = 0;
          run_rd  = 1'b0;
        end
        prev_cnvst = cnvst;
        prev_sck   = sck_en;
      end
    end
  end

  initial begin
    int unsigned fs, mark_wr, mark_cnv;

    wr_tab[0] = '{cfg: 16'h1454, exp_stream: 16'b0001_0100_0101_0100, exp_len: 16};
    wr_tab[1] = '{cfg: 16'hA5C3, exp_stream: 16'b1010_0101_1100_0011, exp_len: 16};
    wr_tab[2] = '{cfg: 16'h8001, exp_stream: 16'b1000_0000_0000_0001, exp_len: 16};
    wr_tab[3] = '{cfg: 16'h0000, exp_stream: 16'b0000_0000_0000_0000, exp_len: 16};

    rstn = 1'b0; acq_en = 1'b0; force_write = 1'b0; cfg_word = '0;
    repeat (3) tick();
    check("reset_outputs", 32'({cnvst, sck_en, sdi, reader_en_sync, frame_start, data_valid,
                                busy}), 0);
    check("reset_sample_cnt", sample_cnt, 0);
    rstn = 1'b1;

    // Continuous acquisition: acq_en sampled at edge 10, five frames, drop mid-CONV of the last.
    wait_until(9);
    acq_en = 1'b1;
    fs = cyc + 2;
    for (int k = 0; k < 5; k++) begin
      fs_q.push_back(fs + k * PeriodCyc);
      dv_q.push_back(fs + DvOfs + k * PeriodCyc);
    end
    wait_until(fs + 4 * PeriodCyc + 5);
    acq_en = 1'b0;
    wait_until(fs + 5 * PeriodCyc + 10);
    check("acq_sample_cnt", sample_cnt, 5);
    check("acq_idle_busy", 32'(busy), 0);

    // Idle configuration writes, cfg_word scrambled right after capture.
    for (int i = 0; i < 4; i++) begin
      cfg_word    = wr_tab[i].cfg;
      force_write = 1'b1;
      mark_wr     = wr_frames;
      mark_cnv    = cnvst_cycles;
      tick();
      force_write = 1'b0;
      cfg_word    = ~wr_tab[i].cfg;
      repeat (20) tick();
      check("wr_frame_count", wr_frames - mark_wr, 1);
      check("wr_len", last_wr_len, wr_tab[i].exp_len);
      check("wr_stream", 32'(last_wr_stream), 32'(wr_tab[i].exp_stream));
      check("wr_no_cnvst", cnvst_cycles - mark_cnv, 0);
      check("wr_idle_busy", 32'(busy), 0);
    end

    // Write requested twice during READ: one frame inserted, period stretched to 96.
    cfg_word = 16'hC3A5;
    tick();
    acq_en  = 1'b1;
    fs      = cyc + 2;
    mark_wr = wr_frames;
    fs_q.push_back(fs);
    dv_q.push_back(fs + DvOfs);
    fs_q.push_back(fs + WrSpace);
    dv_q.push_back(fs + WrSpace + DvOfs);
    wait_until(fs + 30);
    force_write = 1'b1;
    tick();
    force_write = 1'b0;
    wait_until(fs + 33);
    force_write = 1'b1;
    tick();
    force_write = 1'b0;
    wait_until(fs + WrSpace + 5);
    acq_en = 1'b0;
    wait_until(fs + WrSpace + PeriodCyc + 10);
    check("ins_wr_frames", wr_frames - mark_wr, 1);
    check("ins_wr_stream", 32'(last_wr_stream), 32'h0000_C3A5);
    check("ins_sample_cnt", sample_cnt, 7);
    check("ins_idle_busy", 32'(busy), 0);

    // Reset for one cycle during READ: aborted frame yields no data_valid, then resume.
    tick();
    acq_en = 1'b1;
    fs     = cyc + 2;
    fs_q.push_back(fs);
    wait_until(fs + 30);
    rstn = 1'b0;
    fs_q.push_back(fs + 33);
    dv_q.push_back(fs + 33 + DvOfs);
    tick();
    check("midread_rst_outputs", 32'({cnvst, sck_en, sdi, reader_en_sync, frame_start,
                                      data_valid, busy}), 0);
    check("midread_rst_sample_cnt", sample_cnt, 0);
    rstn = 1'b1;
    wait_until(fs + 33 + 5);
    acq_en = 1'b0;
    wait_until(fs + 33 + PeriodCyc + 10);
    check("resume_sample_cnt", sample_cnt, 1);
    check("resume_idle_busy", 32'(busy), 0);

    // force_write and acq_en together in IDLE: write first, frame_start 17 cycles later.
    tick();
    cfg_word    = 16'h5A0F;
    acq_en      = 1'b1;
    force_write = 1'b1;
    mark_wr     = wr_frames;
    fs          = cyc + 1 + 17;
    fs_q.push_back(fs);
    dv_q.push_back(fs + DvOfs);
    tick();
    force_write = 1'b0;
    wait_until(fs + 5);
    acq_en = 1'b0;
    wait_until(fs + PeriodCyc + 10);
    check("joint_wr_frames", wr_frames - mark_wr, 1);
    check("joint_wr_stream", 32'(last_wr_stream), 32'h0000_5A0F);
    check("joint_sample_cnt", sample_cnt, 2);
    check("joint_idle_busy", 32'(busy), 0);

    check("frame_start_events_left", fs_q.size(), 0);
    check("data_valid_events_left", dv_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adc_conv_sequencer.md
Name: adc_conv_sequencer

Overview:
Timing master for the AD4003 deserializer array: one instance drives all ADC modules in parallel.
- Generates the shared CNVST pulse, the SCK burst gate and `reader_en_sync` consumed by every channel shift register.
- Signals a `data_valid` strobe once the delayed-read path has captured a full sample.
- Runs the SDI register-write frame used to configure the converters.
- Sits between the acquisition control registers and the per-module deserializers.

Parameters:
ADC_DATA_WIDTH, 18, bits per conversion (SCK cycles in a read burst)
CONV_CYCLES, 26, CNVST high time in clocks (≥ tCONV max at 80 MHz)
PERIOD_CYCLES, 80, conversion period in clocks (1 MSPS at 80 MHz)
READ_LAT, 4, clocks from last SCK cycle until the read-clock shift registers hold the sample
WR_BITS, 16, bits in a configuration write frame (8-bit command + 8-bit data)
TCQ, 1, simulation clock-to-Q delay

Ports:
adc_spi_clk  in  1  80 MHz sequencer clock
rstn  in  1  synchronous reset, active low
acq_en  in  1  level; high = run continuous conversions
force_write  in  1  single-cycle request to send cfg_word to all ADCs
cfg_word  in  WR_BITS  write frame, MSB first
cnvst  out  1  conversion start to ADCs
sck_en  out  1  SCK gate; SCK toggles only while high
sdi  out  1  serial config data to ADCs
reader_en_sync  out  1  enable for deserializer shift registers
frame_start  out  1  one-cycle pulse on first CONV cycle
data_valid  out  1  one-cycle pulse when adc_data_arr is valid
sample_cnt  out  32  completed-sample counter
busy  out  1  high in any state except IDLE

Behaviour:
- The clock is `adc_spi_clk`; reset is synchronous and active-low on `rstn`.
- Reset: every output is 0 and the state is IDLE, all applied on the first edge with `rstn`=0.
  - A reset mid-frame aborts immediately; no `data_valid` is issued for the aborted frame.
- All outputs are registered. An input sampled at edge k takes effect on outputs from edge k+1.
- States: IDLE, WRITE, CONV, READ, WAIT.
- IDLE exits:
  - If `wr_pending`, go to WRITE.
  - Else if `acq_en`, go to CONV.
  - Otherwise stay in IDLE.
- `wr_pending`:
  - Set by `force_write` in any state.
  - Cleared on WRITE entry; `cfg_word` is captured at that same edge.
  - Repeated requests while pending collapse into one write.
- WRITE:
  - Lasts WR_BITS cycles.
  - `sck_en`=1 throughout.
  - `sdi` = `cfg_word`[WR_BITS-1-i] in cycle i.
  - `cnvst`=0 and `reader_en_sync`=0.
  - Exit to CONV if `acq_en`, else IDLE.
- CONV:
  - `frame_start`=1 in the first cycle.
  - `cnvst`=1 for CONV_CYCLES cycles, then go to READ.
  - `period_cnt` clears to 0 on CONV entry and increments every cycle.
- READ:
  - Lasts ADC_DATA_WIDTH cycles with `sck_en`=1, `reader_en_sync`=1, `sdi`=0 and `cnvst`=0.
  - Then go to WAIT.
- `data_valid`:
  - Pulses exactly READ_LAT cycles after the last READ cycle.
  - It is driven by a delay pipe, so it still fires if the state has already moved on.
  - `sample_cnt` increments on that same edge and wraps 2^32-1 → 0.
- WAIT:
  - Hold until `period_cnt` = PERIOD_CYCLES-1.
  - Then, checked in this order:
    - If `wr_pending`, go to WRITE (the write frame is inserted and the period is stretched by WR_BITS).
    - Else if `acq_en`, go to CONV, giving an exact PERIOD_CYCLES spacing between `frame_start` pulses.
    - Else go to IDLE.
- Deasserting `acq_en` mid-frame never truncates the frame; the frame completes and its `data_valid` is issued.
- Legal parameters require PERIOD_CYCLES ≥ CONV_CYCLES + ADC_DATA_WIDTH + READ_LAT + 1.
  - Violation: simulation `$error` at elaboration.
  - The RTL behaviour in that case is undefined.
- `busy`=1 in WRITE, CONV, READ and WAIT.

Test Plan:
- Reset then `acq_en`=1 at cycle 10 → `cnvst` high cycles 11–36, `sck_en`/`reader_en_sync` high cycles 37–54, `data_valid` at cycle 58, next `frame_start` at cycle 91; 5 frames → `sample_cnt`=5, all `frame_start` spacings exactly 80.
- Idle, `force_write` with `cfg_word`=0x1454 → 16 `sck_en` cycles with `sdi` serialising 0001_0100_0101_0100 MSB first; `cnvst`=0 throughout; return to IDLE with `busy`=0.
- `force_write` pulsed during READ of a running acquisition → current frame completes, 16-cycle write inserted after WAIT, next `frame_start` at 96 cycles instead of 80, `data_valid` count unaffected.
- `acq_en` dropped in the middle of CONV → frame finishes, one more `data_valid`, then IDLE; no further `cnvst`.
- `rstn` low for one cycle during READ → all outputs 0 next cycle, no `data_valid` for that frame, `sample_cnt`=0; resumes from IDLE.
- `force_write` and `acq_en` rising together in IDLE → WRITE first, then CONV immediately after (`frame_start` on cycle 17 after request).
